// File: rtl/stopwatch_core.sv
// stopwatch_core: debounced start/clear control and BCD MM:SS.cc counter driven by a sampled 100 Hz clock
module stopwatch_core #(
  parameter int DEBOUNCE_CNT = 999999
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       clk_100Hz,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic       running,
  output logic       overflow,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones
);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_nx;
  logic       t_s1, t_s2, t_dly, tick;
  logic [1:0] key_raw, press;
  logic       clr, cnt_en;
  logic       w0, w1, w2, w3, w4, w5;
  // 100 Hz edge detect, registered so digits move on the 4th edge after the rising edge
  always_ff @(posedge clk_50MHz or negedge rst_n)
    if (!rst_n) begin
      t_s1  <= 1'b0;
      t_s2  <= 1'b0;
      t_dly <= 1'b0;
      tick  <= 1'b0;
    end else begin
      t_s1  <= clk_100Hz;
      t_s2  <= t_s1;
      t_dly <= t_s2;
      tick  <= t_s2 & ~t_dly;
    end
  assign key_raw = {key_clear_n, key_start_n};
  for (genvar i = 0; i < 2; i++) begin : g_key
    logic          s1, s2, deb, p;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_50MHz or negedge rst_n)
      if (!rst_n) begin
        s1  <= 1'b1;
        s2  <= 1'b1;
        deb <= 1'b1;
        cnt <= '0;
        p   <= 1'b0;
      end else begin
        s1  <= key_raw[i];
        s2  <= s1;
        p   <= 1'b0;
        if (s2 == deb) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CNT)) begin
          cnt <= '0;
          deb <= s2;
          p   <= ~s2;
        end else cnt <= cnt + 1'b1;
      end
    assign press[i] = p;
  end
  always_ff @(posedge clk_50MHz or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == RUN) ? (press[0] ? PAUSE : RUN) :
               press[1]       ? IDLE :
               press[0]       ? RUN  : state;
  always_comb begin
    running = (state == RUN);
    clr     = press[1] & (state != RUN);
    cnt_en  = tick & (state == RUN);
  end
  assign w0 = (cs_ones  == 4'd9);
  assign w1 = w0 & (cs_tens  == 4'd9);
  assign w2 = w1 & (sec_ones == 4'd9);
  assign w3 = w2 & (sec_tens == 4'd5);
  assign w4 = w3 & (min_ones == 4'd9);
  assign w5 = w4 & (min_tens == 4'd5);
  always_ff @(posedge clk_50MHz or negedge rst_n)
    if (!rst_n || clr) begin
      {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} <= '0;
      overflow <= 1'b0;
    end else if (cnt_en) begin
      cs_ones  <= w0 ? 4'd0 : cs_ones + 4'd1;
      cs_tens  <= w0 ? (w1 ? 4'd0 : cs_tens  + 4'd1) : cs_tens;
      sec_ones <= w1 ? (w2 ? 4'd0 : sec_ones + 4'd1) : sec_ones;
      sec_tens <= w2 ? (w3 ? 4'd0 : sec_tens + 4'd1) : sec_tens;
      min_ones <= w3 ? (w4 ? 4'd0 : min_ones + 4'd1) : min_ones;
      min_tens <= w4 ? (w5 ? 4'd0 : min_tens + 4'd1) : min_tens;
      overflow <= overflow | w5;
    end
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed plus randomized checks of stopwatch_core against a centisecond-count reference model
module tb_stopwatch_core;
  logic clk_50MHz = 1'b0, rst_n = 1'b0, clk_100Hz = 1'b0;
  logic key_start_n = 1'b1, key_clear_n = 1'b1;
  logic running, overflow;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones;
  int checks = 0, failures = 0;
  int m_t = 0;
  bit m_run = 0, m_ovf = 0;
  int run_edges = 0;
  logic run_d = 1'b0;

  stopwatch_core #(.DEBOUNCE_CNT(15)) dut (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .clk_100Hz(clk_100Hz),
    .key_start_n(key_start_n), .key_clear_n(key_clear_n),
    .running(running), .overflow(overflow),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .cs_tens(cs_tens), .cs_ones(cs_ones)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(negedge clk_50MHz) begin
    if (running === 1'b1 && run_d === 1'b0) run_edges++;
    run_d = running;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic model_tick();
    if (m_run) begin
      m_t++;
      if (m_t == 360000) begin
        m_t = 0;
        m_ovf = 1;
      end
    end
  endtask

  task automatic model_press(input bit s, input bit c);
    if (m_run) begin
      if (s) m_run = 0;
    end else if (c) begin
      m_t = 0;
      m_ovf = 0;
    end else if (s) m_run = 1;
  endtask

  task automatic ticks(input int n, input int half);
    repeat (n) begin
      clk_100Hz = 1'b1;
      cyc(half);
      clk_100Hz = 1'b0;
      cyc(half);
      model_tick();
    end
  endtask

  // random short bounces (never stable for 16 cycles), then a clean hold and release
  task automatic press(input bit s, input bit c);
    int nb;
    nb = $urandom_range(0, 3);
    repeat (nb) begin
      key_start_n = ~s; key_clear_n = ~c;
      cyc($urandom_range(1, 8));
      key_start_n = 1'b1; key_clear_n = 1'b1;
      cyc($urandom_range(1, 8));
    end
    key_start_n = ~s; key_clear_n = ~c;
    cyc(24 + $urandom_range(0, 20));
    key_start_n = 1'b1; key_clear_n = 1'b1;
    cyc(24);
    model_press(s, c);
  endtask

  // start pulse lands in the same cycle as the tick pulse
  task automatic press_on_tick();
    key_start_n = 1'b0;
    cyc(15);
    clk_100Hz = 1'b1;
    cyc(20);
    clk_100Hz = 1'b0;
    key_start_n = 1'b1;
    cyc(24);
    if (m_run) begin
      m_t++;
      m_run = 0;
    end else m_run = 1;
  endtask

  task automatic chk(input string tag);
    logic [23:0] obs, exp;
    int cs, s, m;
    cs = m_t % 100;
    s = (m_t / 100) % 60;
    m = m_t / 6000;
    exp = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    obs = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s digits observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (running === m_run) else begin
      failures++;
      $error("FAIL %s running observed=%b expected=%b", tag, running, m_run);
    end
    checks++;
    assert (overflow === m_ovf) else begin
      failures++;
      $error("FAIL %s overflow observed=%b expected=%b", tag, overflow, m_ovf);
    end
  endtask

  initial begin
    int e0;
    cyc(3);
    chk("reset");
    rst_n = 1'b1;
    cyc(2);
    e0 = run_edges;
    for (int i = 0; i < 12; i++) begin
      key_start_n = i[0];
      cyc(5);
    end
    key_start_n = 1'b0;
    cyc(30);
    key_start_n = 1'b1;
    cyc(24);
    model_press(1, 0);
    chk("bounce_start");
    checks++;
    assert (run_edges - e0 == 1) else begin
      failures++;
      $error("FAIL bounce_pulses observed=%0d expected=1", run_edges - e0);
    end
    ticks(7, 20);
    chk("tick7");
    ticks(93, 20);
    chk("tick100");
    press(0, 1);
    ticks($urandom_range(3, 12), 4);
    chk("clear_in_run");
    press(1, 0);
    ticks(10, 20);
    chk("pause_frozen");
    press(0, 1);
    chk("clear_in_pause");
    press(1, 0);
    ticks(5, 4);
    chk("at05");
    press_on_tick();
    chk("coinc_run_to_pause");
    press_on_tick();
    chk("coinc_pause_to_run");
    ticks(1, 20);
    chk("after_coinc");
    press(1, 1);
    chk("both_in_run");
    press(1, 1);
    chk("both_in_pause");
    press(1, 0);
    ticks(3, 4);
    press(1, 0);
    force dut.min_tens = 4'd5; force dut.min_ones = 4'd9;
    force dut.sec_tens = 4'd5; force dut.sec_ones = 4'd9;
    force dut.cs_tens  = 4'd9; force dut.cs_ones  = 4'd9;
    cyc(1);
    release dut.min_tens; release dut.min_ones;
    release dut.sec_tens; release dut.sec_ones;
    release dut.cs_tens;  release dut.cs_ones;
    m_t = 359999;
    cyc(1);
    chk("preload");
    press(1, 0);
    ticks(1, 20);
    chk("wrap");
    ticks($urandom_range(2, 9), 4);
    chk("ovf_sticky_run");
    press(1, 0);
    ticks(2, 4);
    chk("ovf_sticky_pause");
    press(0, 1);
    chk("ovf_cleared");
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: press(1, 0);
        1: press(0, 1);
        2: press(1, 1);
        default: ticks($urandom_range(1, 60), 4);
      endcase
      chk("random");
    end
    if (m_run) press(1, 0);
    press(0, 1);
    press(1, 0);
    ticks(1234, 4);
    chk("at1234");
    @(posedge clk_50MHz);
    #3 rst_n = 1'b0;
    #1;
    m_t = 0; m_run = 0; m_ovf = 0;
    chk("async_reset");
    cyc(3);
    rst_n = 1'b1;
    ticks(5, 20);
    chk("idle_after_reset");
    press(1, 0);
    ticks(3, 20);
    chk("restart");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
